// File: rtl/snn_pkg.sv
// Shared types and helpers for the spiking-neuron layer: FSM state encoding,
// a width-generic saturation helper and the default firing threshold.
package snn_pkg;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } fsm_state_e;

    localparam logic signed [15:0] DEFAULT_THRESHOLD = 16'sh0960;

    // Clamp a sign-extended value into the signed range of a w-bit word.
    // Callers size-cast the result down to w bits.
    function automatic logic signed [63:0] sat(input logic signed [63:0] x, input int unsigned w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (x > hi) begin
            return hi;
        end else if (x < lo) begin
            return lo;
        end
        return x;
    endfunction

endpackage

// File: rtl/lif_cell.sv
// One leaky integrate-and-fire neuron: membrane potential with arithmetic-shift
// leak, saturating integration, threshold/refractory handling and a saturating
// spike counter for the current window.
module lif_cell
    import snn_pkg::*;
#(
    parameter int                       DATA_W     = 16,
    parameter logic signed [DATA_W-1:0] THRESHOLD  = DEFAULT_THRESHOLD,
    parameter int                       LEAK_SHIFT = 4,
    parameter int                       REFRACT    = 8,
    parameter int                       RESET_MODE = 0,
    parameter int                       CNT_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              step,
    input  logic              flush,
    input  logic              clear,
    input  logic [DATA_W-1:0] in_current,
    output logic              spike,
    output logic [CNT_W-1:0]  live_cnt
);

    // Two guard bits are enough for v - leak + in before clamping.
    localparam int EW = DATA_W + 2;
    localparam int RW = (REFRACT > 0) ? $clog2(REFRACT + 1) : 1;

    logic signed [DATA_W-1:0] v_q;
    logic [RW-1:0]            refr_q;
    logic                     spike_q;
    logic [CNT_W-1:0]         cnt_q;

    logic signed [DATA_W-1:0] leak;
    logic signed [EW-1:0]     v_ext;
    logic signed [EW-1:0]     leak_ext;
    logic signed [EW-1:0]     in_ext;
    logic signed [EW-1:0]     sum_ext;
    logic signed [EW-1:0]     sub_ext;
    logic signed [63:0]       sum_wide;
    logic signed [63:0]       sub_wide;
    logic signed [DATA_W-1:0] v_next;
    logic signed [DATA_W-1:0] v_fire_d;
    logic signed [DATA_W-1:0] thr;
    logic                     fire;

    // Candidate next potential, threshold test and post-spike potential.
    always_comb begin
        thr      = THRESHOLD;
        leak     = (LEAK_SHIFT == 0) ? '0 : (v_q >>> LEAK_SHIFT);
        v_ext    = {{2{v_q[DATA_W-1]}}, v_q};
        leak_ext = {{2{leak[DATA_W-1]}}, leak};
        in_ext   = {{2{in_current[DATA_W-1]}}, in_current};
        sum_ext  = v_ext - leak_ext + in_ext;
        sum_wide = {{(64 - EW){sum_ext[EW-1]}}, sum_ext};
        v_next   = DATA_W'(sat(sum_wide, DATA_W));
        fire     = (v_next >= thr);
        sub_ext  = {{2{v_next[DATA_W-1]}}, v_next} - {{2{thr[DATA_W-1]}}, thr};
        sub_wide = {{(64 - EW){sub_ext[EW-1]}}, sub_ext};
        v_fire_d = (RESET_MODE == 1) ? DATA_W'(sat(sub_wide, DATA_W)) : '0;
    end

    // Neuron state update; any restart source wipes the window state.
    always_ff @(posedge clk) begin
        if (rst || clear || flush) begin
            v_q     <= '0;
            refr_q  <= '0;
            cnt_q   <= '0;
            spike_q <= 1'b0;
        end else if (step) begin
            if (refr_q != '0) begin
                refr_q  <= refr_q - 1'b1;
                spike_q <= 1'b0;
            end else if (fire) begin
                spike_q <= 1'b1;
                v_q     <= v_fire_d;
                refr_q  <= RW'(REFRACT);
                if (cnt_q != '1) begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end else begin
                v_q     <= v_next;
                spike_q <= 1'b0;
            end
        end else begin
            spike_q <= 1'b0;
        end
    end

    assign spike    = spike_q;
    assign live_cnt = cnt_q;

endmodule

// File: rtl/lif_neuron_array.sv
// Array of LIF neurons with a window sequencer: counts enabled steps, then
// spends one flush cycle publishing per-channel spike counts and the most
// active channel before the next window starts.
module lif_neuron_array
    import snn_pkg::*;
#(
    parameter int                       N_CH       = 10,
    parameter int                       DATA_W     = 16,
    parameter logic signed [DATA_W-1:0] THRESHOLD  = DEFAULT_THRESHOLD,
    parameter int                       LEAK_SHIFT = 4,
    parameter int                       REFRACT    = 8,
    parameter int                       RESET_MODE = 0,
    parameter int                       T_WINDOW   = 250,
    parameter int                       CNT_W      = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     clear,
    input  logic [N_CH*DATA_W-1:0]   in_current,
    output logic [N_CH-1:0]          out_spike,
    output logic [N_CH*CNT_W-1:0]    spike_cnt,
    output logic [$clog2(N_CH)-1:0]  winner,
    output logic                     winner_valid,
    output logic                     window_done
);

    localparam int IDX_W  = $clog2(N_CH);
    localparam int STEP_W = $clog2(T_WINDOW);

    fsm_state_e              state_q;
    logic [STEP_W-1:0]       step_q;
    logic [N_CH*CNT_W-1:0]   spike_cnt_q;
    logic [IDX_W-1:0]        winner_q;
    logic                    winner_valid_q;
    logic                    window_done_q;

    logic                    cell_step;
    logic                    cell_flush;
    logic [CNT_W-1:0]        live_cnt [N_CH];
    logic [CNT_W-1:0]        max_cnt;
    logic [IDX_W-1:0]        max_idx;

    assign cell_step  = (state_q == ST_RUN) && en;
    assign cell_flush = (state_q == ST_FLUSH);

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_cell
            lif_cell #(
                .DATA_W     (DATA_W),
                .THRESHOLD  (THRESHOLD),
                .LEAK_SHIFT (LEAK_SHIFT),
                .REFRACT    (REFRACT),
                .RESET_MODE (RESET_MODE),
                .CNT_W      (CNT_W)
            ) u_cell (
                .clk        (clk),
                .rst        (rst),
                .step       (cell_step),
                .flush      (cell_flush),
                .clear      (clear),
                .in_current (in_current[gi*DATA_W +: DATA_W]),
                .spike      (out_spike[gi]),
                .live_cnt   (live_cnt[gi])
            );
        end
    endgenerate

    // Argmax over live counts; strict compare keeps the lowest index on ties.
    always_comb begin
        max_cnt = live_cnt[0];
        max_idx = '0;
        for (int i = 1; i < N_CH; i++) begin
            if (live_cnt[i] > max_cnt) begin
                max_cnt = live_cnt[i];
                max_idx = IDX_W'(i);
            end
        end
    end

    // Window sequencer and published result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_RUN;
            step_q         <= '0;
            spike_cnt_q    <= '0;
            winner_q       <= '0;
            winner_valid_q <= 1'b0;
            window_done_q  <= 1'b0;
        end else if (clear) begin
            state_q       <= ST_RUN;
            step_q        <= '0;
            window_done_q <= 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    window_done_q <= 1'b0;
                    if (en) begin
                        if (step_q == STEP_W'(T_WINDOW - 1)) begin
                            step_q  <= '0;
                            state_q <= ST_FLUSH;
                        end else begin
                            step_q <= step_q + 1'b1;
                        end
                    end
                end
                ST_FLUSH: begin
                    for (int i = 0; i < N_CH; i++) begin
                        spike_cnt_q[i*CNT_W +: CNT_W] <= live_cnt[i];
                    end
                    winner_q       <= max_idx;
                    winner_valid_q <= (max_cnt != '0);
                    window_done_q  <= 1'b1;
                    state_q        <= ST_RUN;
                end
                default: begin
                    state_q       <= ST_RUN;
                    window_done_q <= 1'b0;
                end
            endcase
        end
    end

    assign spike_cnt    = spike_cnt_q;
    assign winner       = winner_q;
    assign winner_valid = winner_valid_q;
    assign window_done  = window_done_q;

endmodule
